// File: rtl/branch_target_predictor_if.sv
// Fetch/execute side of the branch target buffer: lookup request, prediction,
// resolved-branch update, flush and performance counters.
interface branch_target_predictor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 32
);
    logic                  lookup_valid;
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  pred_hit;
    logic                  pred_taken;
    logic [PC_WIDTH-1:0]   pred_next_pc;

    logic                  upd_valid;
    logic [PC_WIDTH-1:0]   upd_pc;
    logic                  upd_taken;
    logic [PC_WIDTH-1:0]   upd_target;
    logic                  upd_mispredict;
    logic                  flush;

    logic [STAT_WIDTH-1:0] stat_lookups;
    logic [STAT_WIDTH-1:0] stat_hits;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    modport master (
        output lookup_valid, lookup_pc,
        input  pred_hit, pred_taken, pred_next_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        input  stat_lookups, stat_hits, stat_mispredicts
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        output pred_hit, pred_taken, pred_next_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        output stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and
// saturating performance counters; lookup is combinational from registered state.
module branch_target_predictor #(
    parameter int PC_WIDTH     = 32,
    parameter int INDEX_BITS   = 4,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_WIDTH   = 32
) (
    input logic                    clock,
    input logic                    reset,
    branch_target_predictor_if.slave bus
);
    localparam int ENTRIES   = 1 << INDEX_BITS;
    localparam int TAG_WIDTH = PC_WIDTH - INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
    localparam logic [STAT_WIDTH-1:0]   STAT_MAX = '1;

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]    tag_q    [ENTRIES];
    logic [TAG_WIDTH-1:0]    tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0]     target_q [ENTRIES];
    logic [PC_WIDTH-1:0]     target_d [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_d    [ENTRIES];

    logic [STAT_WIDTH-1:0]   lookups_q, lookups_d;
    logic [STAT_WIDTH-1:0]   hits_q, hits_d;
    logic [STAT_WIDTH-1:0]   mispredicts_q, mispredicts_d;

    logic [INDEX_BITS-1:0]   lk_idx, up_idx;
    logic [TAG_WIDTH-1:0]    lk_tag, up_tag;
    logic                    lk_hit, lk_taken, up_hit;

    assign lk_idx = bus.lookup_pc[INDEX_BITS-1:0];
    assign lk_tag = bus.lookup_pc[PC_WIDTH-1:INDEX_BITS];
    assign up_idx = bus.upd_pc[INDEX_BITS-1:0];
    assign up_tag = bus.upd_pc[PC_WIDTH-1:INDEX_BITS];

    // Lookup reads only registered state, so a same-cycle update is not forwarded.
    always_comb begin
        lk_hit   = bus.lookup_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][COUNTER_BITS-1];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    assign bus.pred_hit     = lk_hit;
    assign bus.pred_taken   = lk_taken;
    assign bus.pred_next_pc = lk_taken ? target_q[lk_idx] : bus.lookup_pc + PC_WIDTH'(1);

    // Flush wins over a same-cycle update; a miss only allocates when taken.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.flush) begin
            valid_d = '0;
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    target_d[up_idx] = bus.upd_target;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 1'b1;
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 1'b1;
                end
            end else if (bus.upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                ctr_d[up_idx]    = CTR_WEAK;
            end
        end
    end

    always_comb begin
        lookups_d     = lookups_q;
        hits_d        = hits_q;
        mispredicts_d = mispredicts_q;
        if (bus.lookup_valid && lookups_q != STAT_MAX) begin
            lookups_d = lookups_q + STAT_WIDTH'(1);
        end
        if (lk_hit && hits_q != STAT_MAX) begin
            hits_d = hits_q + STAT_WIDTH'(1);
        end
        if (bus.upd_valid && bus.upd_mispredict && mispredicts_q != STAT_MAX) begin
            mispredicts_d = mispredicts_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q       <= '0;
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            valid_q       <= valid_d;
            lookups_q     <= lookups_d;
            hits_q        <= hits_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    // Payload fields are meaningless while the entry is invalid, so they carry no reset.
    always_ff @(posedge clock) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

    assign bus.stat_lookups     = lookups_q;
    assign bus.stat_hits        = hits_q;
    assign bus.stat_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: a behavioural table model predicts
// every lookup and stat counter; a second instance with 4-bit stats checks saturation.
module tb_branch_target_predictor;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_target_predictor_if #(.PC_WIDTH(32), .STAT_WIDTH(32)) bus ();
    branch_target_predictor_if #(.PC_WIDTH(32), .STAT_WIDTH(4))  small_bus ();

    assign small_bus.lookup_valid   = bus.lookup_valid;
    assign small_bus.lookup_pc      = bus.lookup_pc;
    assign small_bus.upd_valid      = bus.upd_valid;
    assign small_bus.upd_pc         = bus.upd_pc;
    assign small_bus.upd_taken      = bus.upd_taken;
    assign small_bus.upd_target     = bus.upd_target;
    assign small_bus.upd_mispredict = bus.upd_mispredict;
    assign small_bus.flush          = bus.flush;

    branch_target_predictor #(
        .PC_WIDTH(32), .INDEX_BITS(4), .COUNTER_BITS(2), .STAT_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    branch_target_predictor #(
        .PC_WIDTH(32), .INDEX_BITS(4), .COUNTER_BITS(2), .STAT_WIDTH(4)
    ) dut_small (
        .clock(clock), .reset(reset), .bus(small_bus)
    );

    typedef struct {
        bit          lv;
        logic [31:0] lpc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        bit          um;
        bit          fl;
        bit          rst;
    } stim_t;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] next;
    } exp_t;

    exp_t exp_q[$];

    bit          m_valid  [16];
    logic [27:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    longint      m_lk, m_hit, m_mis;
    longint      s_lk, s_hit, s_mis;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mkStim(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc,
                                     bit ut, logic [31:0] utgt, bit um, bit fl, bit rst);
        stim_t s;
        s.lv = lv; s.lpc = lpc; s.uv = uv; s.upc = upc; s.ut = ut;
        s.utgt = utgt; s.um = um; s.fl = fl; s.rst = rst;
        return s;
    endfunction

    function automatic exp_t modelLookup(bit lv, logic [31:0] pc);
        exp_t e;
        int   idx = int'(pc[3:0]);
        e.hit   = lv && m_valid[idx] && (m_tag[idx] == pc[31:4]);
        e.taken = e.hit && (m_ctr[idx] >= 2);
        e.next  = e.taken ? m_target[idx] : pc + 32'd1;
        return e;
    endfunction

    function automatic longint satInc(longint v, longint max);
        return (v < max) ? v + 1 : v;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_lk = 0; m_hit = 0; m_mis = 0;
        s_lk = 0; s_hit = 0; s_mis = 0;
    endfunction

    function automatic void modelUpdate(stim_t s, bit lk_hit);
        int idx;
        bit uh;
        if (s.rst) begin
            modelReset();
            return;
        end
        if (s.lv) begin m_lk = satInc(m_lk, 64'hFFFF_FFFF); s_lk = satInc(s_lk, 15); end
        if (lk_hit) begin m_hit = satInc(m_hit, 64'hFFFF_FFFF); s_hit = satInc(s_hit, 15); end
        if (s.uv && s.um) begin m_mis = satInc(m_mis, 64'hFFFF_FFFF); s_mis = satInc(s_mis, 15); end
        if (s.fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (s.uv) begin
            idx = int'(s.upc[3:0]);
            uh  = m_valid[idx] && (m_tag[idx] == s.upc[31:4]);
            if (uh) begin
                if (s.ut) begin
                    m_target[idx] = s.utgt;
                    if (m_ctr[idx] < 3) m_ctr[idx]++;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else if (s.ut) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = s.upc[31:4];
                m_target[idx] = s.utgt;
                m_ctr[idx]    = 2;
            end
        end
    endfunction

    task automatic applyStimulus(input stim_t s, input bit chk = 1'b0, input logic eh = 1'b0,
                                 input logic et = 1'b0, input logic [31:0] en = 32'd0);
        exp_t e;
        exp_t got;
        bus.lookup_valid   = s.lv;
        bus.lookup_pc      = s.lpc;
        bus.upd_valid      = s.uv;
        bus.upd_pc         = s.upc;
        bus.upd_taken      = s.ut;
        bus.upd_target     = s.utgt;
        bus.upd_mispredict = s.um;
        bus.flush          = s.fl;
        reset              = s.rst;
        e = modelLookup(s.lv, s.lpc);
        exp_q.push_back(e);
        @(negedge clock);
        got = exp_q.pop_front();
        checkOutput("pred_hit", 64'(bus.pred_hit), 64'(got.hit));
        checkOutput("pred_taken", 64'(bus.pred_taken), 64'(got.taken));
        checkOutput("pred_next_pc", 64'(bus.pred_next_pc), 64'(got.next));
        if (chk) begin
            checkOutput("plan_hit", 64'(bus.pred_hit), 64'(eh));
            checkOutput("plan_taken", 64'(bus.pred_taken), 64'(et));
            checkOutput("plan_next_pc", 64'(bus.pred_next_pc), 64'(en));
        end
        @(posedge clock);
        modelUpdate(s, e.hit);
        #1;
        checkOutput("stat_lookups", 64'(bus.stat_lookups), m_lk);
        checkOutput("stat_hits", 64'(bus.stat_hits), m_hit);
        checkOutput("stat_mispredicts", 64'(bus.stat_mispredicts), m_mis);
        checkOutput("small_stat_lookups", 64'(small_bus.stat_lookups), s_lk);
        checkOutput("small_stat_hits", 64'(small_bus.stat_hits), s_hit);
        checkOutput("small_stat_mispredicts", 64'(small_bus.stat_mispredicts), s_mis);
    endtask

    task automatic doLookup(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] en);
        applyStimulus(mkStim(1, pc, 0, 0, 0, 0, 0, 0, 0), 1'b1, eh, et, en);
    endtask

    task automatic doUpdate(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        applyStimulus(mkStim(0, 0, 1, pc, taken, tgt, 0, 0, 0));
    endtask

    initial begin
        longint mis_before;
        longint lk_before;

        reset              = 1'b1;
        bus.lookup_valid   = 1'b0;
        bus.lookup_pc      = 32'd0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 32'd0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 32'd0;
        bus.upd_mispredict = 1'b0;
        bus.flush          = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        modelReset();
        checkOutput("reset_stat_lookups", 64'(bus.stat_lookups), 64'd0);
        checkOutput("reset_stat_hits", 64'(bus.stat_hits), 64'd0);
        checkOutput("reset_stat_mispredicts", 64'(bus.stat_mispredicts), 64'd0);
        checkOutput("reset_next_pc", 64'(bus.pred_next_pc), 64'd1);

        doLookup(32'h10, 0, 0, 32'h11);
        checkOutput("first_stat_lookups", 64'(bus.stat_lookups), 64'd1);
        checkOutput("first_stat_hits", 64'(bus.stat_hits), 64'd0);

        doUpdate(32'h10, 1, 32'h40);
        doLookup(32'h10, 1, 1, 32'h40);

        doUpdate(32'h10, 0, 32'h0);
        doUpdate(32'h10, 0, 32'h0);
        doLookup(32'h10, 1, 0, 32'h11);
        doUpdate(32'h10, 0, 32'h0);
        doLookup(32'h10, 1, 0, 32'h11);
        doUpdate(32'h10, 1, 32'h40);
        doLookup(32'h10, 1, 0, 32'h11);
        doUpdate(32'h10, 1, 32'h40);
        doLookup(32'h10, 1, 1, 32'h40);
        doUpdate(32'h10, 1, 32'h40);
        doUpdate(32'h10, 1, 32'h40);
        doUpdate(32'h10, 0, 32'h0);
        doLookup(32'h10, 1, 1, 32'h40);
        doUpdate(32'h10, 0, 32'h0);
        doLookup(32'h10, 1, 0, 32'h11);
        doUpdate(32'h10, 1, 32'h44);
        doLookup(32'h10, 1, 1, 32'h44);

        doUpdate(32'h20, 1, 32'h80);
        doLookup(32'h10, 0, 0, 32'h11);
        doLookup(32'h20, 1, 1, 32'h80);
        doUpdate(32'h30, 0, 32'h90);
        doLookup(32'h20, 1, 1, 32'h80);

        doUpdate(32'h13, 1, 32'h99);
        applyStimulus(mkStim(1, 32'h13, 1, 32'h23, 1, 32'h77, 0, 0, 0), 1'b1, 1, 1, 32'h99);
        doLookup(32'h23, 1, 1, 32'h77);
        doLookup(32'h13, 0, 0, 32'h14);

        doLookup(32'hFFFF_FFFF, 0, 0, 32'h0);

        mis_before = m_mis;
        lk_before  = m_lk;
        applyStimulus(mkStim(0, 0, 1, 32'h50, 1, 32'hAA, 1, 1, 0));
        checkOutput("flush_mispredicts", 64'(bus.stat_mispredicts), mis_before + 1);
        checkOutput("flush_lookups", 64'(bus.stat_lookups), lk_before);
        doLookup(32'h20, 0, 0, 32'h21);
        doLookup(32'h50, 0, 0, 32'h51);
        doLookup(32'h23, 0, 0, 32'h24);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(mkStim($urandom_range(0, 1), 32'($urandom_range(0, 63)),
                                 $urandom_range(0, 1), 32'($urandom_range(0, 63)),
                                 $urandom_range(0, 2) != 0, $urandom,
                                 $urandom_range(0, 1), $urandom_range(0, 31) == 0,
                                 $urandom_range(0, 99) == 0));
        end

        doUpdate(32'h10, 1, 32'h40);
        applyStimulus(mkStim(0, 0, 1, 32'h10, 1, 32'h40, 1, 0, 1));
        checkOutput("midreset_stat_lookups", 64'(bus.stat_lookups), 64'd0);
        checkOutput("midreset_stat_mispredicts", 64'(bus.stat_mispredicts), 64'd0);
        doLookup(32'h10, 0, 0, 32'h11);

        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mkStim(1, 32'($urandom_range(0, 255)), 0, 0, 0, 0, 0, 0, 0));
        end
        checkOutput("sat_small_lookups", 64'(small_bus.stat_lookups), 64'd15);
        checkOutput("sat_main_lookups", 64'(bus.stat_lookups), 64'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised branch target buffer (BTB) with per-entry saturating direction counters. It produces the next fetch PC for the pipelined core's fetch stage. Lookup is combinational from registered state, so the PC register can consume the result in the same cycle. Resolved branches from execute update the table on the rising clock edge, and saturating performance counters track lookups, hits and mispredicts.

Parameters:
PC_WIDTH, 32, width of word-addressed PC and targets.
INDEX_BITS, 4, table index width; ENTRIES = 2^INDEX_BITS; tag width = PC_WIDTH-INDEX_BITS.
COUNTER_BITS, 2, direction counter width (>=1); predict taken when counter MSB = 1.
STAT_WIDTH, 32, width of each performance counter.

Ports:
clock  in  1  master clock, rising edge active.
reset  in  1  synchronous, active-high; clears table valid bits and all stat counters.
lookup_valid  in  1  fetch is presenting a PC this cycle.
lookup_pc  in  PC_WIDTH  current fetch PC.
pred_hit  out  1  valid entry with matching tag exists for lookup_pc (gated by lookup_valid).
pred_taken  out  1  pred_hit AND counter MSB.
pred_next_pc  out  PC_WIDTH  predicted next PC.
upd_valid  in  1  resolved branch/jump update this cycle.
upd_pc  in  PC_WIDTH  PC of resolved instruction.
upd_taken  in  1  actual direction.
upd_target  in  PC_WIDTH  actual target.
upd_mispredict  in  1  the pipeline flushed for this update; used only by the stat counter.
flush  in  1  invalidate all entries.
stat_lookups  out  STAT_WIDTH  count of cycles with lookup_valid.
stat_hits  out  STAT_WIDTH  count of cycles with lookup_valid AND pred_hit.
stat_mispredicts  out  STAT_WIDTH  count of upd_valid AND upd_mispredict.

Behaviour:
- Storage per entry:
  - valid bit: cleared by reset and by flush.
  - tag, target and counter: not reset; they are don't-care while valid = 0.
- Lookup (combinational):
  - idx = lookup_pc[INDEX_BITS-1:0], tag = lookup_pc[PC_WIDTH-1:INDEX_BITS].
  - pred_hit = lookup_valid & valid[idx] & (tag matches).
  - pred_next_pc = pred_taken ? target[idx] : lookup_pc+1, modulo 2^PC_WIDTH (0xFFFFFFFF wraps to 0x00000000).
  - When lookup_valid = 0: pred_hit = 0, pred_taken = 0, pred_next_pc = lookup_pc+1.
- Reset output values: stat_* = 0. With every valid bit clear, pred_hit = pred_taken = 0 and pred_next_pc = lookup_pc+1.
- Update (rising edge, upd_valid = 1, flush = 0):
  - Index and tag are taken from upd_pc.
  - Hit:
    - counter increments if upd_taken, else decrements, saturating at 0 and 2^COUNTER_BITS-1.
    - target := upd_target only if upd_taken.
  - Miss and upd_taken = 1: allocate. valid := 1, tag written, target := upd_target, counter := 2^(COUNTER_BITS-1) (weakly taken). Any existing entry at that index with a different tag is overwritten; the table is direct-mapped with no replacement policy.
  - Miss and upd_taken = 0: no table change.
- flush:
  - Clears all valid bits at the edge.
  - Has priority over a same-cycle update; that update is discarded from the table but still counts toward stat_mispredicts.
  - Stat counters are unaffected.
- Same-cycle lookup and update to the same index: the lookup sees pre-update state (no write-through). The update is visible on the next cycle.
- Stat counters:
  - Each counter increments by 1 per qualifying cycle.
  - Each saturates at 2^STAT_WIDTH-1 and never wraps.
  - All are cleared only by reset.
- reset mid-operation: takes effect at the next edge regardless of upd_valid or flush. The table is empty and the counters are 0 on the following cycle.
- Latency: lookup 0 cycles; update visible 1 cycle after the edge.

Test Plan:
- Reset, then lookup_valid = 1, lookup_pc = 0x10 -> pred_hit = 0, pred_next_pc = 0x11. One cycle later stat_lookups = 1, stat_hits = 0.
- Update upd_pc = 0x10, upd_taken = 1, upd_target = 0x40; next cycle look up 0x10 -> pred_hit = 1, pred_taken = 1, pred_next_pc = 0x40 (counter = 2).
- Counter saturation on entry 0x10:
  - Two not-taken updates give counter 1 then 0. Lookup 0x10 then shows pred_hit = 1, pred_taken = 0, next = 0x11.
  - A third not-taken update leaves the counter at 0.
  - Four taken updates give 1, 2, 3, 3.
- Aliasing: with 0x10 allocated, a taken update to 0x20 (target 0x80; same idx 0, different tag) -> lookup 0x10 misses, next = 0x11; lookup 0x20 -> next = 0x80. A not-taken update to 0x30 leaves the 0x20 entry intact.
- flush asserted together with a taken update to 0x50 (upd_mispredict = 1) -> all lookups miss next cycle, no entry for 0x50, stat_mispredicts increments by 1, stat_lookups unchanged by the flush.
- Boundaries:
  - Lookup and update to index 3 in the same cycle -> the lookup reflects the old entry.
  - lookup_pc = 0xFFFFFFFF on a miss -> pred_next_pc = 0x00000000.
  - With STAT_WIDTH = 4, 20 consecutive lookups -> stat_lookups = 15.
  - reset asserted during an update -> table empty and stats 0 next cycle.
